// File: rtl/retire_trace_pkg.sv
// Shared types for the retire-trace producer: record codes,
// statistic indices, serialiser states and the commit entry.
package retire_trace_pkg;

   localparam logic [2:0] T_REG   = 3'd1;
   localparam logic [2:0] T_LOAD  = 3'd2;
   localparam logic [2:0] T_STORE = 3'd3;
   localparam logic [2:0] T_STAT  = 3'd4;
   localparam logic [2:0] T_HALT  = 3'd5;

   localparam logic [2:0] ST_CYCLE = 3'd0;
   localparam logic [2:0] ST_INST  = 3'd1;
   localparam logic [2:0] ST_DHIT  = 3'd2;
   localparam logic [2:0] ST_IHIT  = 3'd3;
   localparam logic [2:0] ST_DREQ  = 3'd4;
   localparam logic [2:0] ST_IREQ  = 3'd5;

   localparam int ENTRY_W = 87;

   // STAT0..HALT are consecutive so the stat walk is a +1 step
   typedef enum logic [3:0] {
      S_IDLE, S_REG, S_MEM,
      S_STAT0, S_STAT1, S_STAT2,
      S_STAT3, S_STAT4, S_STAT5,
      S_HALT, S_DONE
   } state_t;

   typedef struct packed {
      logic        regwrite;
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic        memread;
      logic        memwrite;
      logic [15:0] addr;
      logic [15:0] mdin;
      logic [15:0] mdout;
      logic        halt;
      logic [15:0] pc;
   } entry_t;

   function automatic state_t first_state(entry_t e);
      state_t s;
      priority case (1'b1)
         e.regwrite:             s = S_REG;
         e.memread | e.memwrite: s = S_MEM;
         e.halt:                 s = S_STAT0;
         default:                s = S_IDLE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO exposing the head and the entry behind it
// so the serialiser can move to the next entry without a bubble.
module trace_fifo #(
   parameter int W     = 87,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           head,
   output logic [W-1:0]           second,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head   = mem[rp];
   assign second = mem[rp + AW'(1)];
   assign full   = count == CW'(DEPTH);
   assign empty  = count == '0;

endmodule

// File: rtl/retire_trace_tx.sv
// Retire-trace producer: buffers commit effects and serialises them
// as typed records, ending with statistics and a HALT record.
module retire_trace_tx
   import retire_trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ev_valid,
   input  logic        ev_regwrite,
   input  logic [2:0]  ev_wreg,
   input  logic [15:0] ev_wdata,
   input  logic        ev_memread,
   input  logic        ev_memwrite,
   input  logic [15:0] ev_addr,
   input  logic [15:0] ev_mdin,
   input  logic [15:0] ev_mdout,
   input  logic        ev_halt,
   input  logic [15:0] ev_pc,
   input  logic        icache_req,
   input  logic        icache_hit,
   input  logic        dcache_req,
   input  logic        dcache_hit,
   output logic        commit_stall,
   output logic        tr_valid,
   input  logic        tr_ready,
   output logic [2:0]  tr_type,
   output logic [15:0] tr_tag,
   output logic [31:0] tr_data,
   output logic        overflow,
   output logic        err,
   output logic        done
);
   localparam int CW = $clog2(DEPTH) + 1;

   entry_t           ev_e, head, second, ent_d;
   logic [CW-1:0]    count;
   logic             full, empty;
   logic             has_flags, acc, hs, last, more;
   logic             halted;
   logic [2:0]       type_d, idx;
   logic [15:0]      tag_d;
   logic [31:0]      data_d;
   logic [CNT_W-1:0] cnt [6];
   state_t           state, state_d;

   assign ev_e = {ev_regwrite, ev_wreg, ev_wdata,
                  ev_memread, ev_memwrite, ev_addr,
                  ev_mdin, ev_mdout, ev_halt, ev_pc};

   assign has_flags = ev_valid & (ev_regwrite | ev_memread
                    | ev_memwrite | ev_halt);
   assign hs   = tr_valid & tr_ready;
   assign more = count >= CW'(2);

   // the active entry stays at the FIFO head until its last record
   assign last = hs & (
        (state == S_REG & ~(head.memread | head.memwrite) & ~head.halt)
      | (state == S_MEM & ~head.halt)
      | (state == S_HALT));

   assign acc = has_flags & ~halted & (~full | last);

   assign commit_stall = full;
   assign tr_valid     = (state != S_IDLE) & (state != S_DONE);
   assign done         = state == S_DONE;

   trace_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (acc),
      .pop    (last),
      .din    (ev_e),
      .head   (head),
      .second (second),
      .full   (full),
      .empty  (empty),
      .count  (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d = state;
      ent_d   = head;
      unique case (state)
         S_IDLE: if (!empty) state_d = first_state(head);
         S_REG: if (hs) begin
            if (head.memread | head.memwrite) state_d = S_MEM;
            else if (head.halt)               state_d = S_STAT0;
         end
         S_MEM:   if (hs && head.halt) state_d = S_STAT0;
         S_HALT:  if (hs) state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: if (hs) state_d = state_t'(state + 4'd1);
      endcase
      if (last && state != S_HALT) begin
         state_d = more ? first_state(second) : S_IDLE;
         ent_d   = second;
      end
   end

   always_comb begin
      type_d = '0;
      tag_d  = '0;
      data_d = '0;
      idx    = 3'(state_d - S_STAT0);
      unique case (state_d)
         S_IDLE, S_DONE: begin end
         S_REG: begin
            type_d = T_REG;
            tag_d  = {13'b0, ent_d.wreg};
            data_d = {16'b0, ent_d.wdata};
         end
         S_MEM: begin
            type_d = ent_d.memwrite ? T_STORE : T_LOAD;
            tag_d  = ent_d.addr;
            data_d = {16'b0, ent_d.memwrite ? ent_d.mdin
                                            : ent_d.mdout};
         end
         S_HALT: begin
            type_d = T_HALT;
            tag_d  = ent_d.pc;
         end
         default: begin
            type_d = T_STAT;
            tag_d  = {13'b0, idx};
            data_d = 32'(cnt[idx]);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tr_type <= '0;
         tr_tag  <= '0;
         tr_data <= '0;
      end else if (!(tr_valid && !tr_ready)) begin
         tr_type <= type_d;
         tr_tag  <= tag_d;
         tr_data <= data_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halted   <= 1'b0;
         overflow <= 1'b0;
         err      <= 1'b0;
         for (int i = 0; i < 6; i++) cnt[i] <= '0;
      end else begin
         if (acc && ev_halt) halted <= 1'b1;
         if (has_flags && !halted && full && !last)
            overflow <= 1'b1;
         if (acc && ev_memread && ev_memwrite) err <= 1'b1;
         if (!halted) begin
            cnt[ST_CYCLE] <= cnt[ST_CYCLE] + CNT_W'(1);
            if (acc && (ev_halt || ev_regwrite || ev_memwrite))
               cnt[ST_INST] <= cnt[ST_INST] + CNT_W'(1);
            if (dcache_hit) cnt[ST_DHIT] <= cnt[ST_DHIT] + CNT_W'(1);
            if (icache_hit) cnt[ST_IHIT] <= cnt[ST_IHIT] + CNT_W'(1);
            if (dcache_req) cnt[ST_DREQ] <= cnt[ST_DREQ] + CNT_W'(1);
            if (icache_req) cnt[ST_IREQ] <= cnt[ST_IREQ] + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_retire_trace_tx.sv
// Bench for retire_trace_tx: a record-level model predicts the
// trace stream from the committed events it drives.
module tb_retire_trace_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ev_valid = 0, ev_regwrite = 0, ev_memread = 0;
   logic        ev_memwrite = 0, ev_halt = 0;
   logic [2:0]  ev_wreg = 0;
   logic [15:0] ev_wdata = 0, ev_addr = 0, ev_mdin = 0;
   logic [15:0] ev_mdout = 0, ev_pc = 0;
   logic        icache_req = 0, icache_hit = 0;
   logic        dcache_req = 0, dcache_hit = 0;
   logic        commit_stall, tr_valid, tr_ready = 0;
   logic [2:0]  tr_type;
   logic [15:0] tr_tag;
   logic [31:0] tr_data;
   logic        overflow, err, done;

   typedef logic [50:0] rec_t;
   rec_t        got[$];
   rec_t        exp_q[$];
   int          got_t[$];
   int          tests = 0, fails = 0, cyc_n = 0;
   int unsigned m_cnt [6];
   bit          m_halted, m_err, m_drop, rand_ready, ireq_hi;

   always #5 clk = ~clk;

   retire_trace_tx dut (
      .clk(clk), .rst(rst),
      .ev_valid(ev_valid), .ev_regwrite(ev_regwrite),
      .ev_wreg(ev_wreg), .ev_wdata(ev_wdata),
      .ev_memread(ev_memread), .ev_memwrite(ev_memwrite),
      .ev_addr(ev_addr), .ev_mdin(ev_mdin), .ev_mdout(ev_mdout),
      .ev_halt(ev_halt), .ev_pc(ev_pc),
      .icache_req(icache_req), .icache_hit(icache_hit),
      .dcache_req(dcache_req), .dcache_hit(dcache_hit),
      .commit_stall(commit_stall), .tr_valid(tr_valid),
      .tr_ready(tr_ready), .tr_type(tr_type), .tr_tag(tr_tag),
      .tr_data(tr_data), .overflow(overflow), .err(err),
      .done(done)
   );

   // one clock: randomise strobes, log handshakes, update the model
   task automatic cyc();
      bit acc;
      if (rand_ready) tr_ready = ($urandom_range(0, 3) != 0);
      dcache_req = 1'($urandom_range(0, 1));
      dcache_hit = dcache_req & 1'($urandom_range(0, 1));
      icache_hit = 1'($urandom_range(0, 1));
      icache_req = ireq_hi | 1'($urandom_range(0, 1));
      #1;
      if (tr_valid && tr_ready) begin
         got.push_back({tr_type, tr_tag, tr_data});
         got_t.push_back(cyc_n);
      end
      acc = rst && ev_valid && !m_halted && !m_drop &&
            (ev_regwrite || ev_memread || ev_memwrite || ev_halt);
      if (rst && !m_halted) begin
         m_cnt[0]++;
         if (acc && (ev_halt || ev_regwrite || ev_memwrite))
            m_cnt[1]++;
         if (dcache_hit) m_cnt[2]++;
         if (icache_hit) m_cnt[3]++;
         if (dcache_req) m_cnt[4]++;
         if (icache_req) m_cnt[5]++;
      end
      if (acc) begin
         if (ev_regwrite)
            exp_q.push_back({3'd1, 13'd0, ev_wreg, 16'd0, ev_wdata});
         if (ev_memwrite)
            exp_q.push_back({3'd3, ev_addr, 16'd0, ev_mdin});
         else if (ev_memread)
            exp_q.push_back({3'd2, ev_addr, 16'd0, ev_mdout});
         if (ev_memread && ev_memwrite) m_err = 1;
         if (ev_halt) begin
            m_halted = 1;
            for (int k = 0; k < 6; k++)
               exp_q.push_back({3'd4, 16'(k), 32'(m_cnt[k])});
            exp_q.push_back({3'd5, ev_pc, 32'd0});
         end
      end
      @(posedge clk);
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic send(input bit rw, input logic [2:0] wr,
                       input logic [15:0] wd, input bit mr,
                       input bit mw, input logic [15:0] a,
                       input logic [15:0] di, input logic [15:0] dq,
                       input bit h, input logic [15:0] pc);
      for (int n = 0; n < 200 && commit_stall; n++) cyc();
      ev_valid = 1; ev_regwrite = rw; ev_wreg = wr; ev_wdata = wd;
      ev_memread = mr; ev_memwrite = mw; ev_addr = a;
      ev_mdin = di; ev_mdout = dq; ev_halt = h; ev_pc = pc;
      cyc();
      ev_valid = 0;
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && got.size() < exp_q.size(); n++)
         cyc();
      repeat (3) cyc();
   endtask

   task automatic do_reset();
      rst = 0;
      ev_valid = 0;
      repeat (2) cyc();
      rst = 1;
      m_cnt = '{default: 0};
      m_halted = 0;
      m_err = 0;
      got.delete();
      exp_q.delete();
      got_t.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({tr_valid, tr_type, tr_tag, tr_data} !== 52'd0) begin
         fails++;
         $display("FAIL reset_rec got %h want 0",
                  {tr_valid, tr_type, tr_tag, tr_data});
      end
      tests++;
      if ({commit_stall, overflow, err, done} !== 4'b0) begin
         fails++;
         $display("FAIL reset_flags got %b want 0000",
                  {commit_stall, overflow, err, done});
      end
      do_reset();
      tests++;
      if ({tr_valid, commit_stall, done} !== 3'b0) begin
         fails++;
         $display("FAIL reset_idle got %b want 000",
                  {tr_valid, commit_stall, done});
      end
   endtask

   task automatic test_reg();
      int t0;
      tr_ready = 1;
      t0 = cyc_n;
      send(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
      drain();
      tests++;
      if (got.size() != 1 || got[0] !== {3'd1, 16'h3, 32'h1234}) begin
         fails++;
         $display("FAIL reg_rec n=%0d got %h want %h", got.size(),
                  got.size() ? got[0] : '0, {3'd1, 16'h3, 32'h1234});
      end
      tests++;
      if (got_t.size() != 1 || got_t[0] - t0 > 2) begin
         fails++;
         $display("FAIL reg_latency got %0d want <=2",
                  got_t.size() ? got_t[0] - t0 : -1);
      end
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL reg_done got %b want 0", done);
      end
   endtask

   task automatic test_load();
      got.delete(); exp_q.delete(); got_t.delete();
      send(1, 3'd5, 16'hBEEF, 1, 0, 16'h0040, 0, 16'hBEEF, 0, 0);
      drain();
      tests++;
      if (got.size() != 2) begin
         fails++;
         $display("FAIL load_count got %0d want 2", got.size());
      end else begin
         tests++;
         if (got[0] !== {3'd1, 16'h5, 32'hBEEF}) begin
            fails++;
            $display("FAIL load_reg got %h want %h", got[0],
                     {3'd1, 16'h5, 32'hBEEF});
         end
         tests++;
         if (got[1] !== {3'd2, 16'h40, 32'hBEEF}) begin
            fails++;
            $display("FAIL load_mem got %h want %h", got[1],
                     {3'd2, 16'h40, 32'hBEEF});
         end
         tests++;
         if (got_t[1] != got_t[0] + 1) begin
            fails++;
            $display("FAIL load_b2b gap got %0d want 1",
                     got_t[1] - got_t[0]);
         end
      end
   endtask

   task automatic test_random();
      int k;
      bit rw, mr, mw;
      got.delete(); exp_q.delete(); got_t.delete();
      rand_ready = 1;
      for (int i = 0; i < 60; i++) begin
         k  = $urandom_range(0, 9);
         mr = (k < 3) || (k == 8);
         mw = (k >= 3 && k < 6) || (k == 8);
         rw = (k == 9) ? 1'b0 : 1'($urandom_range(0, 1));
         send(rw, 3'($urandom), 16'($urandom), mr, mw,
              16'($urandom), 16'($urandom), 16'($urandom), 0, 0);
      end
      drain();
      rand_ready = 0;
      tr_ready = 1;
      tests++;
      if (got.size() != exp_q.size()) begin
         fails++;
         $display("FAIL rand_count got %0d want %0d",
                  got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL rand_rec[%0d] got %h want %h",
                     i, got[i], exp_q[i]);
         end
      end
      tests++;
      if ({err, overflow} !== {m_err, 1'b0}) begin
         fails++;
         $display("FAIL rand_flags err/ovf got %b want %b",
                  {err, overflow}, {m_err, 1'b0});
      end
   endtask

   task automatic test_overflow();
      do_reset();
      tr_ready = 0;
      for (int i = 0; i < 8; i++)
         send(0, 0, 0, 0, 1, 16'(16'h100 + i), 16'($urandom),
              0, 0, 0);
      tests++;
      if (commit_stall !== 1'b1) begin
         fails++;
         $display("FAIL ovf_stall got %b want 1", commit_stall);
      end
      m_drop = 1;
      ev_valid = 1; ev_regwrite = 0; ev_memread = 0;
      ev_memwrite = 1; ev_addr = 16'hDEAD; ev_halt = 0;
      cyc();
      ev_valid = 0;
      m_drop = 0;
      tests++;
      if ({overflow, tr_valid, tr_type} !== {2'b11, 3'd3}) begin
         fails++;
         $display("FAIL ovf_flag got %b want 11011",
                  {overflow, tr_valid, tr_type});
      end
      tr_ready = 1;
      drain();
      tests++;
      if (got.size() != 8 || exp_q.size() != 8) begin
         fails++;
         $display("FAIL ovf_count got %0d want 8", got.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL ovf_rec[%0d] got %h want %h",
                     i, got[i], exp_q[i]);
         end
      end
      tests++;
      if (commit_stall !== 1'b0) begin
         fails++;
         $display("FAIL ovf_unstall got %b want 0", commit_stall);
      end
   endtask

   task automatic test_halt();
      int base, h;
      bit held;
      logic [51:0] snap;
      do_reset();
      tr_ready = 1;
      ireq_hi = 1;
      base = cyc_n;
      for (int i = 0; i < 3; i++)
         send(1, 3'(i + 1), 16'($urandom), 0, 0, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 1, 16'h0080, 16'h5A5A, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020);
      h = cyc_n;
      held = 0;
      for (int n = 0; n < 100 && got.size() < exp_q.size(); n++) begin
         #1;
         if (!held && tr_valid && tr_type == 3'd4 && tr_tag == 16'd2)
         begin
            held = 1;
            snap = {tr_valid, tr_type, tr_tag, tr_data};
            tr_ready = 0;
            repeat (4) begin
               cyc();
               tests++;
               if ({tr_valid, tr_type, tr_tag, tr_data} !== snap) begin
                  fails++;
                  $display("FAIL hold_stat2 got %h want %h",
                           {tr_valid, tr_type, tr_tag, tr_data}, snap);
               end
            end
            tr_ready = 1;
         end
         cyc();
      end
      repeat (3) cyc();
      tests++;
      if (got.size() != 11 || !held) begin
         fails++;
         $display("FAIL halt_count got %0d want 11 (held=%0d)",
                  got.size(), held);
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL halt_rec[%0d] got %h want %h",
                     i, got[i], exp_q[i]);
         end
      end
      if (got.size() == 11) begin
         tests++;
         if (got[4] !== {3'd4, 16'd0, 32'(h - base)}) begin
            fails++;
            $display("FAIL halt_stat0 got %h want cycles %0d",
                     got[4], h - base);
         end
         tests++;
         if (got[5] !== {3'd4, 16'd1, 32'd5}) begin
            fails++;
            $display("FAIL halt_stat1 got %h want inst 5", got[5]);
         end
         tests++;
         if (got[10] !== {3'd5, 16'h0020, 32'd0}) begin
            fails++;
            $display("FAIL halt_rec got %h want pc 0020", got[10]);
         end
      end
      ev_valid = 1; ev_regwrite = 1; ev_memwrite = 1; ev_halt = 0;
      repeat (12) cyc();
      ev_valid = 0;
      tests++;
      if ({done, tr_valid, overflow} !== 3'b100 || got.size() != 11)
      begin
         fails++;
         $display("FAIL halt_quiet done/vld/ovf %b n=%0d want 100 11",
                  {done, tr_valid, overflow}, got.size());
      end
      ireq_hi = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tr_ready = 0;
      for (int i = 0; i < 3; i++)
         send(1, 3'(i), 16'($urandom), 0, 0, 0, 0, 0, 0, 0);
      repeat (2) cyc();
      tests++;
      if (tr_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_busy tr_valid got %b want 1", tr_valid);
      end
      #3;
      rst = 0;
      #1;
      tests++;
      if ({tr_valid, tr_type, tr_tag, tr_data, done, commit_stall}
          !== 54'd0) begin
         fails++;
         $display("FAIL mid_async got %h want 0",
                  {tr_valid, tr_type, tr_tag, tr_data, done});
      end
      @(negedge clk);
      do_reset();
      tr_ready = 1;
      send(1, 3'd6, 16'hC0DE, 0, 0, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100);
      drain();
      tests++;
      if (got.size() != 8 || exp_q.size() != 8) begin
         fails++;
         $display("FAIL mid_count got %0d want 8", got.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL mid_rec[%0d] got %h want %h",
                     i, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reg();
      test_load();
      test_random();
      test_overflow();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule
